viterbi_frame_ctrl: RTL and testbench

//   Frame sequencer for the rate-1/2 Viterbi decoder (clk, rst_n, data_in[1:0], data_out).

---
 rtl/viterbi_frame_ctrl.sv | 111 +++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: clears a rate-1/2 Viterbi decoder, feeds one frame of info and tail symbols,
// flushes it and forwards only the decoded info bits with valid/last markers.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN  = 64,
  parameter int TAIL_LEN   = 2,
  parameter int DEC_LAT    = 4,
  parameter int CLR_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  output logic       busy_o,
  input  logic       sym_valid_i,
  output logic       sym_ready_o,
  input  logic [1:0] sym_data_i,
  output logic       dec_rst_n_o,
  output logic [1:0] dec_data_o,
  input  logic       dec_bit_i,
  output logic       bit_valid_o,
  output logic       bit_data_o,
  output logic       bit_last_o,
  output logic       frame_done_o,
  output logic       err_underrun_o
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, TAIL, FLUSH, ABORT} state_e;
  localparam logic [CNT_W-1:0] CLR_END   = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_END   = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] TAIL_END  = CNT_W'(TAIL_LEN - 1);
  localparam logic [CNT_W-1:0] FLUSH_END = CNT_W'(DEC_LAT);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // tag_q[0] lines up with dec_data_o; tag_q[DEC_LAT] lines up with the matching dec_bit_i
  logic [DEC_LAT:0][1:0] tag_q;
  logic [1:0] tag_d, dec_data_q;
  logic dec_rst_n_q, err_q, bit_valid_q, bit_data_q, bit_last_q;
  logic acc, go, abort_d, tag_clr;
  assign sym_ready_o    = state_q == RUN || state_q == TAIL;
  assign acc            = sym_valid_i && sym_ready_o;
  assign go             = start_i && state_q == IDLE;
  assign abort_d        = state_d == ABORT;
  assign tag_clr        = abort_d || state_q == CLEAR;
  assign tag_d          = {state_q == RUN && acc, state_q == RUN && acc && cnt_q == RUN_END};
  assign busy_o         = state_q != IDLE;
  assign frame_done_o   = state_q == FLUSH && cnt_q == FLUSH_END;
  assign dec_rst_n_o    = dec_rst_n_q;
  assign dec_data_o     = dec_data_q;
  assign err_underrun_o = err_q;
  assign bit_valid_o    = bit_valid_q;
  assign bit_data_o     = bit_data_q;
  assign bit_last_o     = bit_last_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i) state_d = CLEAR;
      end
      CLEAR: if (cnt_q == CLR_END) begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: if (!sym_valid_i) begin
        state_d = ABORT;
        cnt_d   = '0;
      end else if (cnt_q == RUN_END) begin
        state_d = TAIL_LEN == 0 ? FLUSH : TAIL;
        cnt_d   = '0;
      end
      TAIL: if (!sym_valid_i) begin
        state_d = ABORT;
        cnt_d   = '0;
      end else if (cnt_q == TAIL_END) begin
        state_d = FLUSH;
        cnt_d   = '0;
      end
      FLUSH: if (cnt_q == FLUSH_END) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tag_q       <= '0;
      dec_rst_n_q <= 1'b0;
      dec_data_q  <= 2'b00;
      err_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_data_q  <= 1'b0;
      bit_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_clr ? '0 : {tag_q[DEC_LAT-1:0], tag_d};
      dec_rst_n_q <= !(state_d == CLEAR || abort_d);
      dec_data_q  <= acc ? sym_data_i : 2'b00;
      err_q       <= go ? 1'b0 : abort_d || err_q;
      bit_valid_q <= !abort_d && tag_q[DEC_LAT][1];
      bit_data_q  <= dec_bit_i;
      bit_last_q  <= !abort_d && tag_q[DEC_LAT][0];
    end
  end
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: two controllers (DEC_LAT 4 and 1) fed the same (7,5)-encoded frames,
// each driving a behavioural hard-decision decoder; emitted bits are checked against the info bits.
module tb_viterbi_frame_ctrl;
  localparam int FL = 4;
  localparam int TL = 2;
  localparam int NS = FL + TL;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sym_valid = 1'b0;
  logic [1:0] sym_data = 2'b00;
  logic [1:0] busy, sym_ready, dec_rst_n, dec_bit, bit_valid, bit_data, bit_last, frame_done, err;
  logic [1:0][1:0] dec_data;
  int cyc = 0;
  int nerr = 0;
  int nchk = 0;
  logic bv [2][256];
  int bc [2][256];
  int nbits [2] = '{default: 0};
  int nlast [2] = '{default: 0};
  int ndone [2] = '{default: 0};
  int lastc [2] = '{default: 0};
  int donec [2] = '{default: 0};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = g == 0 ? 4 : 1;
    logic [1:0] st = 2'b00;
    logic [L-1:0] dl = '0;
    logic ub;
    assign ub = dec_data[g][1] ^ st[0] ^ st[1];
    assign dec_bit[g] = dl[L-1];
    always @(posedge clk) begin
      st <= dec_rst_n[g] ? {st[0], ub} : 2'b00;
      dl <= L'({dl, ub});
    end
    viterbi_frame_ctrl #(.FRAME_LEN(FL), .TAIL_LEN(TL), .DEC_LAT(L), .CLR_CYCLES(2), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start_i(start), .busy_o(busy[g]),
      .sym_valid_i(sym_valid), .sym_ready_o(sym_ready[g]), .sym_data_i(sym_data),
      .dec_rst_n_o(dec_rst_n[g]), .dec_data_o(dec_data[g]), .dec_bit_i(dec_bit[g]),
      .bit_valid_o(bit_valid[g]), .bit_data_o(bit_data[g]), .bit_last_o(bit_last[g]),
      .frame_done_o(frame_done[g]), .err_underrun_o(err[g])
    );
  end
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (bit_valid[g]) begin
        bv[g][nbits[g] % 256] <= bit_data[g];
        bc[g][nbits[g] % 256] <= cyc;
        nbits[g] <= nbits[g] + 1;
      end
      if (bit_last[g]) begin
        nlast[g] <= nlast[g] + 1;
        lastc[g] <= cyc;
      end
      if (frame_done[g]) begin
        ndone[g] <= ndone[g] + 1;
        donec[g] <= cyc;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int lat(input int g);
    return g == 0 ? 4 : 1;
  endfunction
  task automatic chk_rst_vals();
    for (int g = 0; g < 2; g++)
      chk("reset_vals", {22'd0, busy[g], dec_rst_n[g], dec_data[g], sym_ready[g], bit_valid[g],
                         bit_data[g], bit_last[g], frame_done[g], err[g]}, 32'd0);
  endtask
  // mode 0: normal frame, 1: underrun after ns symbols, 2: rst after ns symbols, 3: rst in flush
  task automatic frame(input logic [FL-1:0] info, input int ns, input int mode, input bit xs);
    logic [1:0] syms [NS];
    int acc [NS];
    int nb0 [2], nl0 [2], nd0 [2], nb1 [2];
    logic s1, s2, ub;
    int k, t;
    s1 = 1'b0;
    s2 = 1'b0;
    for (int i = 0; i < NS; i++) begin
      ub = i < FL ? info[i] : 1'b0;
      syms[i] = {ub ^ s1 ^ s2, ub ^ s2};
      s2 = s1;
      s1 = ub;
      acc[i] = 0;
    end
    for (int g = 0; g < 2; g++) begin
      nb0[g] = nbits[g];
      nl0[g] = nlast[g];
      nd0[g] = ndone[g];
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk("busy_on_start", busy[g], 1);
      chk("err_cleared_by_start", err[g], 0);
    end
    k = 0;
    for (int i = 0; i < 40 && k < ns; i++) begin
      @(negedge clk);
      start = xs && k == 2;
      sym_valid = 1'b0;
      if (sym_ready[0]) begin
        sym_valid = 1'b1;
        sym_data = syms[k];
        acc[k] = cyc;
        k++;
      end
    end
    chk("symbols_fed", k, ns);
    @(negedge clk);
    start = 1'b0;
    sym_valid = 1'b0;
    if (mode >= 2) begin
      rst = 1'b1;
      @(negedge clk);
      chk_rst_vals();
      for (int g = 0; g < 2; g++) nb1[g] = nbits[g];
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        chk("no_bits_after_rst", nbits[g] - nb1[g], 0);
        chk("no_done_after_rst", ndone[g] - nd0[g], 0);
        chk("idle_after_rst", busy[g], 0);
      end
      if (mode == 3) chk("no_last_lat4", nlast[0] - nl0[0], 0);
    end else if (mode == 1) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        chk("abort_cycle", {busy[g], dec_rst_n[g], err[g], sym_ready[g]}, 4'b1010);
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        chk("after_abort", {busy[g], dec_rst_n[g], err[g]}, 3'b011);
      repeat (10) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        chk("abort_no_last", nlast[g] - nl0[g], 0);
        chk("abort_no_done", ndone[g] - nd0[g], 0);
        chk("abort_err_sticky", err[g], 1);
        chk("abort_bits_bound", nbits[g] - nb0[g] <= ns, 1);
      end
    end else begin
      t = 0;
      while (busy != 2'b00 && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("idle_in_time", busy, 0);
      for (int g = 0; g < 2; g++) begin
        chk("bit_count", nbits[g] - nb0[g], FL);
        for (int i = 0; i < FL; i++) begin
          chk("bit_value", bv[g][(nb0[g] + i) % 256], info[i]);
          chk("bit_latency", bc[g][(nb0[g] + i) % 256], acc[i] + lat(g) + 2);
        end
        chk("last_count", nlast[g] - nl0[g], 1);
        chk("last_on_final_bit", lastc[g], bc[g][(nb0[g] + FL - 1) % 256]);
        chk("done_count", ndone[g] - nd0[g], 1);
        chk("done_after_last", donec[g] > lastc[g], 1);
        chk("err_clear", err[g], 0);
      end
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_rst_vals();
    rst = 1'b0;
    frame(4'b1101, NS, 0, 1'b0);
    frame(4'b1101, NS, 0, 1'b1);
    frame(4'b1101, NS, 0, 1'b0);
    frame(4'b1101, 2, 1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      frame(FL'($urandom), NS, 0, 1'($urandom));
    end
    frame(FL'($urandom), 2, 2, 1'b0);
    frame(FL'($urandom), NS, 3, 1'b0);
    frame(4'b1101, NS, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
